// File: rtl/word_lane_serializer.sv
// word_lane_serializer: accepts one WORD_W-bit word per handshake and streams
// its LANE_W-bit lanes out one per cycle. The lane order and the lane count
// are chosen per word. A new word can be accepted on the cycle the previous
// word's last lane transfers, so back-to-back words have no idle bubble.
module word_lane_serializer #(
    parameter int WORD_W  = 32,
    parameter int LANE_W  = 8,
    localparam int N_LANES = WORD_W / LANE_W,
    localparam int CNT_W   = $clog2(N_LANES) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_msb_first,
    input  logic [CNT_W-1:0]  in_lanes,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LANE_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_idx,
    output logic              out_last,
    output logic              busy
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] N_LANES_C = CNT_W'(N_LANES);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    state_t              state_q;
    logic [WORD_W-1:0]   word_q;
    logic                msb_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    idx_q;

    logic [CNT_W-1:0]    cnt_d;
    logic [CNT_W-1:0]    lane_sel;
    logic                out_fire;
    logic                in_take;

    // A requested lane count of 0, or one larger than the word holds, means "all lanes".
    always_comb begin
        cnt_d = in_lanes;
        if (in_lanes == '0 || in_lanes > N_LANES_C) begin
            cnt_d = N_LANES_C;
        end
    end

    assign out_valid = (state_q == SEND);
    assign busy      = (state_q == SEND);
    assign out_idx   = idx_q;
    assign out_last  = (state_q == SEND) && (idx_q == cnt_q - ONE_C);
    assign out_fire  = out_valid & out_ready;
    assign in_ready  = (state_q == IDLE) | (out_fire & out_last);
    assign in_take   = in_valid & in_ready;

    // Map emission position to physical lane; idx_q never exceeds N_LANES-1, so lane_sel stays in range.
    assign lane_sel = msb_q ? (N_LANES_C - ONE_C - idx_q) : idx_q;

    // Lane mux over the held word; only in-range lanes are decoded.
    always_comb begin
        out_data = '0;
        for (int k = 0; k < N_LANES; k++) begin
            if (lane_sel == CNT_W'(k)) begin
                out_data = word_q[k*LANE_W +: LANE_W];
            end
        end
    end

    // Controller: captures a word on input transfer and steps the lane index on each output transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            word_q  <= '0;
            msb_q   <= 1'b0;
            cnt_q   <= N_LANES_C;
            idx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_take) begin
                        state_q <= SEND;
                        word_q  <= in_data;
                        msb_q   <= in_msb_first;
                        cnt_q   <= cnt_d;
                        idx_q   <= '0;
                    end
                end
                SEND: begin
                    if (out_fire) begin
                        if (!out_last) begin
                            idx_q <= idx_q + ONE_C;
                        end else if (in_take) begin
                            word_q <= in_data;
                            msb_q  <= in_msb_first;
                            cnt_q  <= cnt_d;
                            idx_q  <= '0;
                        end else begin
                            state_q <= IDLE;
                            idx_q   <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    idx_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_word_lane_serializer.sv
// Bench for word_lane_serializer: directed literal sequences plus randomized
// traffic compared every cycle against a lane-queue reference model.
module tb_word_lane_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_msb_first;
    logic [2:0]  in_lanes;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [2:0]  out_idx;
    logic        out_last;
    logic        busy;

    logic        v64;
    logic        rdy64_o;
    logic [63:0] d64;
    logic        ov64;
    logic [15:0] od64;
    logic [2:0]  oi64;
    logic        ol64;
    logic        busy64;

    int asserts = 0;
    int fails   = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    word_lane_serializer #(.WORD_W(32), .LANE_W(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_msb_first(in_msb_first), .in_lanes(in_lanes),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .busy(busy)
    );

    word_lane_serializer #(.WORD_W(64), .LANE_W(16)) dut64 (
        .clk(clk), .reset(reset),
        .in_valid(v64), .in_ready(rdy64_o), .in_data(d64),
        .in_msb_first(1'b0), .in_lanes(3'd0),
        .out_valid(ov64), .out_ready(1'b1), .out_data(od64),
        .out_idx(oi64), .out_last(ol64), .busy(busy64)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the pending lanes of the word being emitted, in emission order.
    typedef struct packed {
        logic [7:0] d;
        logic [2:0] idx;
        logic       last;
    } lane_t;
    lane_t q[$];

    function automatic bit model_in_ready();
        return (q.size() == 0) || (q.size() == 1 && out_ready);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
        end else begin
            bit rdy;
            int n;
            int lane;
            rdy = model_in_ready();
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (in_valid && rdy) begin
                n = (in_lanes == 0 || in_lanes > 4) ? 4 : int'(in_lanes);
                for (int p = 0; p < n; p++) begin
                    lane = in_msb_first ? 3 - p : p;
                    q.push_back('{d: in_data[lane*8 +: 8], idx: 3'(p), last: (p == n - 1)});
                end
            end
        end
    end

    // Compare DUT against the model on every falling edge once out of initial reset.
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_out_valid", out_valid, q.size() > 0);
            check("m_busy", busy, q.size() > 0);
            check("m_in_ready", in_ready, model_in_ready());
            if (q.size() > 0) begin
                check("m_out_data", out_data, q[0].d);
                check("m_out_idx", out_idx, q[0].idx);
                check("m_out_last", out_last, q[0].last);
            end
        end
    end

    // Offer one word to an idle DUT with out_ready=1 and check literal lanes (exp packed first-lane-high).
    task automatic lit_word(input logic [31:0] d, input logic msb, input logic [2:0] ln,
                            input int n, input logic [31:0] exp);
        in_valid = 1'b1; in_data = d; in_msb_first = msb; in_lanes = ln; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("lit_valid", out_valid, 1'b1);
            check("lit_busy", busy, 1'b1);
            check("lit_data", out_data, exp[(n-1-i)*8 +: 8]);
            check("lit_idx", out_idx, 3'(i));
            check("lit_last", out_last, (i == n - 1));
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("lit_end_valid", out_valid, 1'b0);
        check("lit_end_busy", busy, 1'b0);
        check("lit_end_ready", in_ready, 1'b1);
        @(posedge clk); #1;
    endtask

    logic [63:0] seq;
    logic [63:0] exp64;

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_msb_first = 1'b0;
        in_lanes = '0; out_ready = 1'b0; v64 = 1'b0; d64 = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1'b1;

        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_out_idx", out_idx, 3'd0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(posedge clk); #1;

        lit_word(32'h12345678, 1'b1, 3'd0, 4, 32'h12345678);
        lit_word(32'h12345678, 1'b0, 3'd2, 2, 32'h00007856);
        lit_word(32'h12345678, 1'b0, 3'd7, 4, 32'h78563412);
        lit_word(32'h000000A5, 1'b0, 3'd1, 1, 32'h000000A5);

        // Backpressure on the second lane.
        in_valid = 1'b1; in_data = 32'h12345678; in_msb_first = 1'b1; in_lanes = 3'd0; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_first", out_data, 8'h12);
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold_data", out_data, 8'h34);
            check("bp_hold_idx", out_idx, 3'd1);
            check("bp_hold_valid", out_valid, 1'b1);
            check("bp_in_ready", in_ready, 1'b0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        seq = 64'h345678;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_data", out_data, seq[(2-i)*8 +: 8]);
            check("bp_idx", out_idx, 3'(i + 1));
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("bp_end_valid", out_valid, 1'b0);
        @(posedge clk); #1;

        // Back-to-back words with in_valid held high.
        in_valid = 1'b1; in_data = 32'hAABBCCDD; in_msb_first = 1'b1; in_lanes = 3'd0;
        @(posedge clk); #1;
        in_data = 32'h11223344;
        seq = 64'hAABBCCDD11223344;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("b2b_valid", out_valid, 1'b1);
            check("b2b_data", out_data, seq[(7-i)*8 +: 8]);
            check("b2b_in_ready", in_ready, (i == 3 || i == 7));
            @(posedge clk); #1;
            if (i == 3) in_valid = 1'b0;
        end
        @(negedge clk);
        check("b2b_end_valid", out_valid, 1'b0);
        @(posedge clk); #1;

        // Reset in the middle of a word.
        in_valid = 1'b1; in_data = 32'h12345678; in_msb_first = 1'b1; in_lanes = 3'd0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("mr_first", out_data, 8'h12);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("mr_valid", out_valid, 1'b0);
        check("mr_busy", busy, 1'b0);
        check("mr_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        lit_word(32'hCAFEF00D, 1'b1, 3'd0, 4, 32'hCAFEF00D);

        // Wide configuration, LSB lane first.
        v64 = 1'b1; d64 = 64'h0123456789ABCDEF;
        @(posedge clk); #1;
        v64 = 1'b0;
        exp64 = 64'hCDEF89AB45670123;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("w64_valid", ov64, 1'b1);
            check("w64_data", od64, exp64[(3-i)*16 +: 16]);
            check("w64_idx", oi64, 3'(i));
            check("w64_last", ol64, (i == 3));
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("w64_end_valid", ov64, 1'b0);
        check("w64_end_busy", busy64, 1'b0);
        @(posedge clk); #1;

        // Randomized traffic, checked by the model process.
        for (int c = 0; c < 2000; c++) begin
            in_valid     = ($urandom_range(0, 3) != 0);
            in_data      = $urandom;
            in_msb_first = $urandom_range(0, 1) == 1;
            in_lanes     = 3'($urandom_range(0, 7));
            out_ready    = ($urandom_range(0, 3) != 0);
            reset        = ($urandom_range(0, 99) == 0);
            @(posedge clk); #1;
        end
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
